// File: rtl/multicycle_sequencer.sv
// Multicycle phase controller: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// and gates the raw decoder enables so each one fires only in its own phase.
module multicycle_sequencer #(
    parameter int          TIMEOUT   = 16,
    parameter int          CNT_WIDTH = 16,
    parameter logic [4:0]  HALT_OP   = 5'b11111
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [4:0]           OPCODE,
    input  logic                 MemRead_d,
    input  logic                 MemWrite_d,
    input  logic                 RegWrite_d,
    input  logic                 MaryWrite_d,
    input  logic                 ShelleyWrite_d,
    input  logic                 CompWrite_d,
    input  logic                 RAWrite_d,
    input  logic                 PCWrite_d,
    input  logic                 SPWrite_d,
    input  logic                 mem_ready,
    output logic                 InstrFetch,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 PCIncr,
    output logic                 CompWrite,
    output logic                 RAWrite,
    output logic                 PCWrite,
    output logic                 SPWrite,
    output logic                 RegWrite,
    output logic                 MaryWrite,
    output logic                 ShelleyWrite,
    output logic [2:0]           state,
    output logic                 halted,
    output logic                 bus_error,
    output logic [CNT_WIDTH-1:0] instr_count
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } stateT;

    stateT             cur, nxt;
    logic [WAIT_W-1:0] waitCnt;
    logic              memPhase, atLimit, anyMem, anyWb, retire, timeout;

    assign memPhase = (cur == FETCH) || (cur == MEM);
    assign atLimit  = (waitCnt == WAIT_W'(TIMEOUT - 1));
    assign anyMem   = MemRead_d | MemWrite_d;
    assign anyWb    = RegWrite_d | MaryWrite_d | ShelleyWrite_d;

    // mem_ready wins over the timeout when both land in the same cycle
    always_comb begin
        nxt     = cur;
        retire  = 1'b0;
        timeout = 1'b0;
        case (cur)
            FETCH: begin
                if (mem_ready)    nxt = DECODE;
                else if (atLimit) begin nxt = HALT; timeout = 1'b1; end
            end
            DECODE: nxt = (OPCODE == HALT_OP) ? HALT : EXEC;
            EXEC: begin
                if (anyMem)      nxt = MEM;
                else if (anyWb)  nxt = WB;
                else             begin nxt = FETCH; retire = 1'b1; end
            end
            MEM: begin
                if (mem_ready) begin
                    if (anyWb) nxt = WB;
                    else       begin nxt = FETCH; retire = 1'b1; end
                end else if (atLimit) begin
                    nxt = HALT; timeout = 1'b1;
                end
            end
            WB:      begin nxt = FETCH; retire = 1'b1; end
            HALT:    nxt = HALT;
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cur         <= FETCH;
            waitCnt     <= '0;
            bus_error   <= 1'b0;
            instr_count <= '0;
        end else begin
            cur     <= nxt;
            // counter restarts on every phase change, so each request gets a fresh budget
            waitCnt <= (memPhase && nxt == cur) ? waitCnt + 1'b1 : '0;
            if (timeout) bus_error   <= 1'b1;
            if (retire)  instr_count <= instr_count + 1'b1;
        end
    end

    always_comb begin
        InstrFetch   = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        PCIncr       = 1'b0;
        CompWrite    = 1'b0;
        RAWrite      = 1'b0;
        PCWrite      = 1'b0;
        SPWrite      = 1'b0;
        RegWrite     = 1'b0;
        MaryWrite    = 1'b0;
        ShelleyWrite = 1'b0;
        if (!Reset) begin
            case (cur)
                FETCH: begin
                    InstrFetch = 1'b1;
                    MemRead    = 1'b1;
                    IRWrite    = mem_ready;
                    PCIncr     = mem_ready;
                end
                EXEC: begin
                    CompWrite = CompWrite_d;
                    RAWrite   = RAWrite_d;
                    PCWrite   = PCWrite_d;
                    SPWrite   = SPWrite_d;
                end
                MEM: begin
                    MemWrite = MemWrite_d;
                    MemRead  = MemRead_d & ~MemWrite_d;
                end
                WB: begin
                    RegWrite     = RegWrite_d;
                    MaryWrite    = MaryWrite_d;
                    ShelleyWrite = ShelleyWrite_d;
                end
                default: ;
            endcase
        end
    end

    assign state  = cur;
    assign halted = (cur == HALT);

endmodule
